game_collision_scheduler: RTL and testbench
===========================================

# game_collision_scheduler

Time-multiplexed collision scheduler for the target layer. On each frame strobe it snapshots the sprite bounding boxes, then steps through every unordered target pair (i<j), one pair per clock, using a single shared overlap comparator instead of an all-pairs combinational array. Per-pair immunity counters suppress repeated hits on the same pair for a fixed number of frames. Registered per-target collision flags and a one-cycle done pulse go to the target movement logic, which reads them once per frame.

## Interface

- N_TARGETS, `N_TARGETS, number of targets; must be ≥ 2
- w_x, $clog2(640), x coordinate width
- w_y, $clog2(480), y coordinate width
- IMMUNITY_FRAMES, 3, frames a pair stays immune after a hit; must be ≥ 1
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- start  in  1  frame strobe; accepted only in IDLE
- enable_targets  in  N_TARGETS  per-target enable, sampled at start
- sprite_left / sprite_right  in  N_TARGETS×w_x  x bounds, sampled at start
- sprite_top / sprite_bottom  in  N_TARGETS×w_y  y bounds, sampled at start
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle pulse; collide outputs updated in this cycle
- collide_x  out  N_TARGETS  per-target hit flags of last completed scan
- collide_y  out  N_TARGETS  identical to collide_x

## Operation

- P = N_TARGETS·(N_TARGETS−1)/2 pairs; pair index counters i, j; per-pair counter width $clog2(IMMUNITY_FRAMES+1).
- States: IDLE, SCAN, DONE.
- IDLE: busy=0. start=1 → snapshot enable_targets and all four bound arrays into internal registers, clear hit accumulator, i=0, j=1, go SCAN.
- SCAN: evaluate pair (i,j) from snapshot, one pair per cycle.
  - counter[i][j] ≠ 0 → decrement by 1, no hit (regardless of enables or overlap).
  - counter == 0, both snapshot enables set, x-overlap and y-overlap → set acc[i] and acc[j], load counter = IMMUNITY_FRAMES.
  - Otherwise no change.
  - x-overlap = left[i] < right[j] && right[i] > left[j]; y-overlap = top[i] < bottom[j] && bottom[i] > top[j]. Comparisons are unsigned and strict; shared edges are not a hit.
  - Pair advance: j = j+1; if j == N_TARGETS−1 then i = i+1, j = i+2. After pair (N_TARGETS−2, N_TARGETS−1), go DONE.
- DONE: collide_x = collide_y = acc, done=1, busy=1; next cycle IDLE.
- A hit in frame k suppresses the pair in frames k+1 … k+IMMUNITY_FRAMES; the pair is eligible again in frame k+IMMUNITY_FRAMES+1. Frames count accepted start strobes only.
- Counters decrement only when their pair is visited, so a disabled pair still counts down its immunity.
- Sprite inputs may change freely during SCAN; only the snapshot is used.

## Timing

- Reset values: state IDLE, busy=0, done=0, collide_x=collide_y=0, all immunity counters 0, accumulator 0, snapshot 0.
- start sampled at edge E0 → SCAN during cycles 1..P → DONE in cycle P+1: done=1 and new collide flags visible → IDLE in cycle P+2.
- start while busy (SCAN or DONE) is ignored, not queued. The minimum start-to-start period is P+2 cycles.
- collide_x and collide_y hold their value from done until the next done; they are not cleared in IDLE.
- rst asserted mid-scan aborts the scan. All state returns to reset values, including immunity counters. No done pulse for the aborted frame.
- start asserted in the same cycle as rst deassertion is not accepted until the first edge after rst is low.

## Test plan

- N_TARGETS=4, targets 0 and 2 overlap ([10,20)×[10,20) vs [15,25)×[15,25)), all enabled, start → done exactly 7 cycles after the start edge, collide=4'b0101, busy high for 7 cycles.
- Same boxes, start every 8 cycles, 5 frames, IMMUNITY_FRAMES=3 → collide = 0101, 0000, 0000, 0000, 0101.
- Touching edges (right[0]=20, left[1]=20, equal y ranges) → collide=0; disable target 2 in the overlapping case → collide=0.
- Pulse start again on every cycle of the scan → all ignored; exactly one done per accepted start; change sprite inputs mid-scan → result matches the snapshot.
- Assert rst at SCAN cycle 3 after a prior hit → outputs 0, no done, counters cleared; next frame with the same overlap → immediate hit 0101.
- N_TARGETS=2, single pair overlapping → done in cycle 2 after the start edge, collide=2'b11.

Source files
------------

// File: rtl/game_collision_scheduler.sv
// Time-multiplexed collision scheduler: one shared overlap comparator walks every
// target pair (i<j) once per frame, with per-pair hit immunity across frames.
module game_collision_scheduler #(
  parameter int unsigned N_TARGETS       = 4,
  parameter int unsigned W_X             = $clog2(640),
  parameter int unsigned W_Y             = $clog2(480),
  parameter int unsigned IMMUNITY_FRAMES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_TARGETS-1:0]     enable_targets,
  input  logic [N_TARGETS*W_X-1:0] sprite_left,
  input  logic [N_TARGETS*W_X-1:0] sprite_right,
  input  logic [N_TARGETS*W_Y-1:0] sprite_top,
  input  logic [N_TARGETS*W_Y-1:0] sprite_bottom,
  output logic                     busy,
  output logic                     done,
  output logic [N_TARGETS-1:0]     collide_x,
  output logic [N_TARGETS-1:0]     collide_y
);

  localparam int unsigned N_PAIRS = N_TARGETS * (N_TARGETS - 1) / 2;
  localparam int unsigned W_I     = $clog2(N_TARGETS);
  localparam int unsigned W_P     = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam int unsigned W_C     = $clog2(IMMUNITY_FRAMES + 1);

  localparam logic [W_I-1:0] I_LAST   = W_I'(N_TARGETS - 2);
  localparam logic [W_I-1:0] J_LAST   = W_I'(N_TARGETS - 1);
  localparam logic [W_C-1:0] CNT_LOAD = W_C'(IMMUNITY_FRAMES);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_next;

  // Frame snapshot
  logic [N_TARGETS-1:0] en_s;
  logic [W_X-1:0]       left_s   [N_TARGETS];
  logic [W_X-1:0]       right_s  [N_TARGETS];
  logic [W_Y-1:0]       top_s    [N_TARGETS];
  logic [W_Y-1:0]       bottom_s [N_TARGETS];

  logic [N_TARGETS-1:0] acc;
  logic [W_C-1:0]       cnt [N_PAIRS];
  logic [W_I-1:0]       pi, pj;
  logic [W_P-1:0]       pidx;

  logic                 snap_c, eval_c, last_pair_c;
  logic                 x_ovl_c, y_ovl_c, immune_c, hit_c;
  logic [N_TARGETS-1:0] acc_hit_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_next = state;
    snap_c     = 1'b0;
    eval_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          snap_c     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        eval_c = 1'b1;
        if (last_pair_c) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shared comparator on the current pair; strict compares so shared edges miss
  always_comb begin
    last_pair_c = (pi == I_LAST) && (pj == J_LAST);
    x_ovl_c     = (left_s[pi] < right_s[pj]) && (right_s[pi] > left_s[pj]);
    y_ovl_c     = (top_s[pi] < bottom_s[pj]) && (bottom_s[pi] > top_s[pj]);
    immune_c    = (cnt[pidx] != '0);
    hit_c       = eval_c && !immune_c && en_s[pi] && en_s[pj] && x_ovl_c && y_ovl_c;
    acc_hit_c   = acc;
    if (hit_c) begin
      acc_hit_c[pi] = 1'b1;
      acc_hit_c[pj] = 1'b1;
    end
  end

  // Snapshot, pair walk, immunity counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      collide_x <= '0;
      collide_y <= '0;
      acc       <= '0;
      en_s      <= '0;
      pi        <= '0;
      pj        <= '0;
      pidx      <= '0;
      for (int k = 0; k < int'(N_TARGETS); k++) begin
        left_s[k]   <= '0;
        right_s[k]  <= '0;
        top_s[k]    <= '0;
        bottom_s[k] <= '0;
      end
      for (int p = 0; p < int'(N_PAIRS); p++) cnt[p] <= '0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);

      if (snap_c) begin
        en_s <= enable_targets;
        for (int k = 0; k < int'(N_TARGETS); k++) begin
          left_s[k]   <= sprite_left[k*W_X +: W_X];
          right_s[k]  <= sprite_right[k*W_X +: W_X];
          top_s[k]    <= sprite_top[k*W_Y +: W_Y];
          bottom_s[k] <= sprite_bottom[k*W_Y +: W_Y];
        end
        acc  <= '0;
        pi   <= '0;
        pj   <= W_I'(1);
        pidx <= '0;
      end

      if (eval_c) begin
        acc <= acc_hit_c;
        // Immune pairs count down on every visit, enabled or not
        if (immune_c)   cnt[pidx] <= cnt[pidx] - W_C'(1);
        else if (hit_c) cnt[pidx] <= CNT_LOAD;
        pidx <= pidx + W_P'(1);
        if (pj == J_LAST) begin
          pi <= pi + W_I'(1);
          pj <= pi + W_I'(2);
        end else begin
          pj <= pj + W_I'(1);
        end
        if (last_pair_c) begin
          collide_x <= acc_hit_c;
          collide_y <= acc_hit_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_collision_scheduler.sv
// Bench for game_collision_scheduler: table-driven frames with a done-driven
// scoreboard, plus hand sequences for busy-start, mid-scan reset and N=2.
module tb_game_collision_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned WX = 10;
  localparam int unsigned WY = 9;
  localparam int unsigned P  = 6;

  typedef struct packed {
    logic            do_rst;
    logic [3:0]      en;
    logic [3:0][9:0] l;
    logic [3:0][9:0] r;
    logic [3:0][8:0] t;
    logic [3:0][8:0] b;
    logic [3:0]      exp;
  } vec_t;

  // Targets 0 and 2 overlap, 1 and 3 far away
  localparam logic [3:0][9:0] OVL_L = {10'd200, 10'd15, 10'd100, 10'd10};
  localparam logic [3:0][9:0] OVL_R = {10'd210, 10'd25, 10'd110, 10'd20};
  localparam logic [3:0][8:0] OVL_T = {9'd200, 9'd15, 9'd100, 9'd10};
  localparam logic [3:0][8:0] OVL_B = {9'd210, 9'd25, 9'd110, 9'd20};
  // Targets 0 and 1 share the x=20 edge with equal y ranges
  localparam logic [3:0][9:0] TCH_L = {10'd200, 10'd300, 10'd20, 10'd0};
  localparam logic [3:0][9:0] TCH_R = {10'd210, 10'd310, 10'd30, 10'd20};
  localparam logic [3:0][8:0] TCH_T = {9'd200, 9'd300, 9'd10, 9'd10};
  localparam logic [3:0][8:0] TCH_B = {9'd210, 9'd310, 9'd20, 9'd20};
  // Hits 0-1 and 0-2; 0-3 share the y=50 edge
  localparam logic [3:0][9:0] MUL_L = {10'd0, 10'd45, 10'd40, 10'd0};
  localparam logic [3:0][9:0] MUL_R = {10'd30, 10'd100, 10'd60, 10'd50};
  localparam logic [3:0][8:0] MUL_T = {9'd50, 9'd0, 9'd40, 9'd0};
  localparam logic [3:0][8:0] MUL_B = {9'd60, 9'd10, 9'd60, 9'd50};

  logic clk = 1'b0;
  logic rst, start, start2;
  logic [N-1:0]    en;
  logic [N*WX-1:0] s_left, s_right;
  logic [N*WY-1:0] s_top, s_bot;
  logic            busy, done;
  logic [N-1:0]    cx, cy;

  logic [1:0]      en2;
  logic [2*WX-1:0] s_left2, s_right2;
  logic [2*WY-1:0] s_top2, s_bot2;
  logic            busy2, done2;
  logic [1:0]      cx2, cy2;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_mon;
  vec_t vecs [12];

  always #5 clk = ~clk;

  game_collision_scheduler #(.N_TARGETS(4), .W_X(WX), .W_Y(WY), .IMMUNITY_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .enable_targets(en),
    .sprite_left(s_left), .sprite_right(s_right), .sprite_top(s_top), .sprite_bottom(s_bot),
    .busy(busy), .done(done), .collide_x(cx), .collide_y(cy)
  );

  game_collision_scheduler #(.N_TARGETS(2), .W_X(WX), .W_Y(WY), .IMMUNITY_FRAMES(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .enable_targets(en2),
    .sprite_left(s_left2), .sprite_right(s_right2), .sprite_top(s_top2), .sprite_bottom(s_bot2),
    .busy(busy2), .done(done2), .collide_x(cx2), .collide_y(cy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic apply(input logic [3:0] e, input logic [3:0][9:0] l, input logic [3:0][9:0] r,
                       input logic [3:0][8:0] t, input logic [3:0][8:0] b);
    en = e; s_left = l; s_right = r; s_top = t; s_bot = b;
  endtask

  // One accepted frame: checks latency and busy width, ends in the first IDLE cycle
  task automatic run_frame(input logic [3:0] e);
    int lat, bcnt;
    start = 1'b1;
    exp_q.push_back(e);
    tick();
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    if (busy) bcnt++;
    check("done_latency", 32'(lat), 32'(P + 1));
    check("busy_cycles", 32'(bcnt), 32'(P + 1));
    tick();
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  // Scoreboard: each done pops the expectation pushed when its start was driven
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending frame at %0t", $time);
      end else begin
        exp_mon = exp_q.pop_front();
        check("collide_x", 32'(cx), 32'(exp_mon));
        check("collide_y", 32'(cy), 32'(exp_mon));
      end
    end
  end

  initial begin
    int d0;
    vecs[0]  = '{1'b1, 4'b1111, OVL_L, OVL_R, OVL_T, OVL_B, 4'b0101};
    vecs[1]  = '{1'b0, 4'b1111, OVL_L, OVL_R, OVL_T, OVL_B, 4'b0000};
    vecs[2]  = '{1'b0, 4'b1111, OVL_L, OVL_R, OVL_T, OVL_B, 4'b0000};
    vecs[3]  = '{1'b0, 4'b1111, OVL_L, OVL_R, OVL_T, OVL_B, 4'b0000};
    vecs[4]  = '{1'b0, 4'b1111, OVL_L, OVL_R, OVL_T, OVL_B, 4'b0101};
    vecs[5]  = '{1'b1, 4'b1111, TCH_L, TCH_R, TCH_T, TCH_B, 4'b0000};
    vecs[6]  = '{1'b1, 4'b1011, OVL_L, OVL_R, OVL_T, OVL_B, 4'b0000};
    vecs[7]  = '{1'b1, 4'b1111, MUL_L, MUL_R, MUL_T, MUL_B, 4'b0111};
    vecs[8]  = '{1'b0, 4'b1111, MUL_L, MUL_R, MUL_T, MUL_B, 4'b0000};
    vecs[9]  = '{1'b0, 4'b0000, MUL_L, MUL_R, MUL_T, MUL_B, 4'b0000};
    vecs[10] = '{1'b0, 4'b1111, MUL_L, MUL_R, MUL_T, MUL_B, 4'b0000};
    vecs[11] = '{1'b0, 4'b1111, MUL_L, MUL_R, MUL_T, MUL_B, 4'b0111};

    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    apply(4'b0000, '0, '0, '0, '0);
    en2 = 2'b11;
    s_left2 = {10'd15, 10'd10};
    s_right2 = {10'd25, 10'd20};
    s_top2 = {9'd15, 9'd10};
    s_bot2 = {9'd25, 9'd20};
    repeat (2) tick();
    check("reset_outputs", {26'd0, busy, done, cx, cy}, 32'd0);
    check("reset_outputs_n2", {26'd0, busy2, done2, cx2, cy2}, 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].do_rst) do_reset();
      apply(vecs[v].en, vecs[v].l, vecs[v].r, vecs[v].t, vecs[v].b);
      run_frame(vecs[v].exp);
    end

    // start held through the whole scan, sprites changed mid-scan
    do_reset();
    apply(4'b1111, OVL_L, OVL_R, OVL_T, OVL_B);
    d0 = done_cnt;
    start = 1'b1;
    exp_q.push_back(4'b0101);
    tick();
    for (int c = 0; c < 7; c++) begin
      if (c == 1) apply(4'b1011, TCH_L, TCH_R, TCH_T, TCH_B);
      tick();
    end
    start = 1'b0;
    repeat (12) tick();
    check("one_done_per_start", 32'(done_cnt - d0), 32'd1);

    // collide holds in IDLE; reset mid-scan aborts and clears immunity
    do_reset();
    apply(4'b1111, OVL_L, OVL_R, OVL_T, OVL_B);
    run_frame(4'b0101);
    repeat (5) tick();
    check("collide_hold_idle", 32'(cx), 32'h5);
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("scan_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_scan_outputs", {26'd0, busy, done, cx, cy}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
    run_frame(4'b0101);

    // Two targets: single pair, done in cycle 2
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("n2_cycle1", {30'd0, busy2, done2}, 32'b10);
    tick();
    check("n2_cycle2", {28'd0, busy2, done2, cx2}, 32'b1111);
    check("n2_collide_y", 32'(cy2), 32'b11);
    tick();
    check("n2_idle", {30'd0, busy2, done2}, 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
